// File: rtl/ysyx_25020037_imem_resp.sv
// ----------------------------------------------------------------------------
// ysyx_25020037_imem_resp
// Memory-side responder for the icache refill port. A level mem_req is turned
// into one AXI4-Lite read (AR then R), and the returned word is handed back as
// a single-cycle mem_ready/mem_data pulse. One read is outstanding at a time.
//
// Optional feature: define YSYX_25020037_IMEM_TIMEOUT_EN to bound the R phase
// to TIMEOUT_CYCLES cycles. On expiry, ERR_DATA is returned and mem_err is set.
// Without the macro, the R phase waits indefinitely for rvalid.
// ----------------------------------------------------------------------------
module ysyx_25020037_imem_resp #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'h0000_0000,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    output logic                  mem_err,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // An AXI read response is good only when it is OKAY.
    function automatic logic resp_is_okay(input logic [1:0] resp);
        return (resp == 2'b00);
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] araddr_r;
    logic [ADDR_WIDTH-1:0] araddr_nxt_s;
    logic                  arvalid_r;
    logic                  arvalid_nxt_s;
    logic                  rready_r;
    logic                  rready_nxt_s;
    logic                  mem_ready_r;
    logic                  mem_ready_nxt_s;
    logic [DATA_WIDTH-1:0] mem_data_r;
    logic [DATA_WIDTH-1:0] mem_data_nxt_s;
    logic                  mem_err_r;
    logic                  mem_err_nxt_s;

`ifdef YSYX_25020037_IMEM_TIMEOUT_EN
    localparam int CNT_W = (($clog2(TIMEOUT_CYCLES) + 1) < 8) ? 8 : ($clog2(TIMEOUT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
`endif

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt_s     = state_r;
        araddr_nxt_s    = araddr_r;
        arvalid_nxt_s   = arvalid_r;
        rready_nxt_s    = rready_r;
        mem_ready_nxt_s = 1'b0;
        mem_data_nxt_s  = {DATA_WIDTH{1'b0}};
        mem_err_nxt_s   = mem_err_r;
`ifdef YSYX_25020037_IMEM_TIMEOUT_EN
        cnt_nxt_s       = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (mem_req) begin
                    araddr_nxt_s  = mem_addr;
                    arvalid_nxt_s = 1'b1;
                    state_nxt_s   = ST_AR;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_AR: begin
                // rvalid is not looked at here: rready is still low.
                if (arready) begin
                    arvalid_nxt_s = 1'b0;
                    rready_nxt_s  = 1'b1;
                    state_nxt_s   = ST_R;
`ifdef YSYX_25020037_IMEM_TIMEOUT_EN
                    cnt_nxt_s     = {CNT_W{1'b0}};
`endif
                end else begin
                    state_nxt_s   = ST_AR;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    rready_nxt_s    = 1'b0;
                    mem_ready_nxt_s = 1'b1;
                    state_nxt_s     = ST_HOLD;
                    if (resp_is_okay(rresp)) begin
                        mem_data_nxt_s = rdata;
                    end else begin
                        mem_data_nxt_s = ERR_DATA;
                        mem_err_nxt_s  = 1'b1;
                    end
                end else begin
`ifdef YSYX_25020037_IMEM_TIMEOUT_EN
                    if (cnt_r == CNT_LAST) begin
                        rready_nxt_s    = 1'b0;
                        mem_ready_nxt_s = 1'b1;
                        mem_data_nxt_s  = ERR_DATA;
                        mem_err_nxt_s   = 1'b1;
                        state_nxt_s     = ST_HOLD;
                    end else begin
                        cnt_nxt_s       = cnt_r + CNT_ONE;
                        state_nxt_s     = ST_R;
                    end
`else
                    state_nxt_s = ST_R;
`endif
                end
            end
            ST_HOLD: begin
                // The cache still holds mem_req during the cycle after the
                // pulse; waiting here prevents a duplicate read of that line.
                if (mem_req) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                arvalid_nxt_s = 1'b0;
                rready_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            araddr_r    <= {ADDR_WIDTH{1'b0}};
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            mem_ready_r <= 1'b0;
            mem_data_r  <= {DATA_WIDTH{1'b0}};
            mem_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            araddr_r    <= araddr_nxt_s;
            arvalid_r   <= arvalid_nxt_s;
            rready_r    <= rready_nxt_s;
            mem_ready_r <= mem_ready_nxt_s;
            mem_data_r  <= mem_data_nxt_s;
            mem_err_r   <= mem_err_nxt_s;
        end
    end

`ifdef YSYX_25020037_IMEM_TIMEOUT_EN
    // R-phase wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`endif

    assign araddr    = araddr_r;
    assign arvalid   = arvalid_r;
    assign rready    = rready_r;
    assign mem_ready = mem_ready_r;
    assign mem_data  = mem_data_r;
    assign mem_err   = mem_err_r;

endmodule

// File: doc/ysyx_25020037_imem_resp.md
Name: ysyx_25020037_imem_resp

Overview:
Memory-side responder for the instruction-cache refill port. It answers the cache's level `mem_req` with a single `mem_data`/`mem_ready` pulse, and fetches that word over an AXI4-Lite read channel (AR/R) to the instruction memory or crossbar. It sits between the icache and the system bus. It handles one outstanding read at a time.

Parameters:
- ADDR_WIDTH, 32, width of the request address and `araddr`.
- DATA_WIDTH, 32, width of the refill word and `rdata`.
- ERR_DATA, 32'h0000_0000, word returned on an AXI error response (and on timeout when enabled).
- TIMEOUT_CYCLES, 256, R-phase cycle limit; only used with IMEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  in  1  refill request from icache; level, held until after `mem_ready`.
- mem_addr  in  ADDR_WIDTH  refill address; valid while `mem_req`=1.
- mem_data  out  DATA_WIDTH  refill word; valid only in the `mem_ready` cycle.
- mem_ready  out  1  one-cycle completion pulse.
- mem_err  out  1  sticky error flag; cleared only by reset.
- araddr  out  ADDR_WIDTH  AXI read address.
- arvalid  out  1  AXI read address valid.
- arready  in  1  AXI read address ready.
- rdata  in  DATA_WIDTH  AXI read data.
- rresp  in  2  AXI read response; 2'b00 is OKAY, anything else is an error.
- rvalid  in  1  AXI read data valid.
- rready  out  1  AXI read data ready.

Behaviour:
- Reset (asynchronous, `rst_n`=0):
  - state=IDLE.
  - `mem_ready`=0, `mem_data`=0, `mem_err`=0.
  - `arvalid`=0, `rready`=0, `araddr`=0.
  - Reset mid-transaction abandons the transaction immediately. No AXI completion is awaited.
- All outputs are registered.
- States:
  - IDLE: when `mem_req`=1, latch `mem_addr` into `araddr`, set `arvalid`=1, go to AR.
  - AR: hold `arvalid`=1 and `araddr` stable until `arready`=1. On that handshake cycle, set `arvalid`=0 and `rready`=1 next cycle, go to R.
  - R: hold `rready`=1 until `rvalid`=1. On handshake:
    - set `rready`=0;
    - `mem_data` = `rdata` if `rresp`=00, else ERR_DATA and set `mem_err`;
    - `mem_ready`=1 for exactly one cycle;
    - go to HOLD.
  - HOLD: `mem_ready`=0, `mem_data`=0. Stay until `mem_req`=0, then go to IDLE.
- HOLD is mandatory. The cache drops `mem_req` only in the cycle after `mem_ready`, so without HOLD a second, spurious read would be issued.
- Latency:
  - Minimum from `mem_req` rising to `mem_ready` is 3 cycles (IDLE→AR, AR handshake, R handshake), with `arready` and `rvalid` already high.
  - Each AXI wait cycle adds one.
- `mem_req` dropping in AR or R: the transaction still completes on AXI (no abort). `mem_ready` still pulses; the cache ignores it.
- `mem_addr` changes after the IDLE latch are ignored.
- `arready` and `rvalid` asserted in the same cycle while in AR: `rvalid` is ignored. The R handshake occurs only while `rready`=1.
- Data width is passed through unchanged. No byte-lane selection; the address is forwarded as-is.

Optional Feature:
- Macro: YSYX_25020037_IMEM_TIMEOUT_EN.
- Defined:
  - An 8..`$clog2(TIMEOUT_CYCLES)+1`-bit counter clears on entry to R and increments each R cycle without `rvalid`.
  - When the count reaches TIMEOUT_CYCLES:
    - return ERR_DATA with a `mem_ready` pulse, set `mem_err`, set `rready`=0;
    - go to HOLD, then IDLE.
  - A late `rvalid` arriving in IDLE or HOLD is ignored, because `rready`=0.
- Undefined: no counter; R waits indefinitely.

Test Plan:
- Single fetch, zero wait: `mem_req`=1, `mem_addr`=32'h8000_0004, `arready`=1, `rvalid`=1, `rdata`=32'h0010_0093, `rresp`=0.
  → `araddr`=32'h8000_0004 with one `arvalid` handshake; `mem_ready` pulse 3 cycles after request with `mem_data`=32'h0010_0093; `mem_err`=0.
- Back-pressure: `arready` low for 4 cycles, `rvalid` low for 5 cycles.
  → `arvalid` and `araddr` stable throughout; `mem_ready` at cycle 12; exactly one AR handshake.
- HOLD check: the cache model keeps `mem_req` high one cycle after `mem_ready`, and a second request for 32'h8000_0008 follows.
  → no AR issued during the overlap cycle; second `araddr`=32'h8000_0008.
- Error response: `rresp`=2'b10.
  → `mem_data`=ERR_DATA on the `mem_ready` pulse; `mem_err`=1 and stays 1 through later OKAY fetches.
- Reset mid-R: assert `rst_n`=0 while in R.
  → all outputs 0 asynchronously; after release, a new request completes normally.
- With YSYX_25020037_IMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, `rvalid` never asserted.
  → `mem_ready` with ERR_DATA after 16 R cycles; `mem_err`=1; `rready`=0 afterward.
